conv_window_gen: RTL
====================

# conv_window_gen

Streaming front end for the convolutional layer. It accepts one raster-ordered pixel per handshake, applies one pixel of zero padding on every edge, and emits one 3×3 window per output pixel, in raster order, to the convolution datapath. It replaces whole-frame padded storage with two line buffers, so the conv core consumes ready-made windows instead of indexing a frame array.

## Interface
- `DATA_W`, 16: bits per channel sample.
- `CH`, 3: channels packed per pixel; pixel width `PIX_W` = `CH*DATA_W`.
- `IMG_W`, 256: input frame width in pixels.
- `IMG_H`, 256: input frame height in pixels.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `in_pixel` is valid.
- `in_ready`  out  1  block accepts `in_pixel` this cycle.
- `in_pixel`  in  `PIX_W`  channel c at `[c*DATA_W +: DATA_W]`.
- `out_valid`  out  1  `out_window` is valid.
- `out_ready`  in  1  downstream accepts the window.
- `out_window`  out  `9*PIX_W`  tap t = 3*kr+kc at `[t*PIX_W +: PIX_W]`; kr=0 is the top row, kc=0 is the left column.
- `out_first`  out  1  window centred on (0,0); qualified by `out_valid`.
- `out_last`  out  1  window centred on (IMG_H-1, IMG_W-1).

## Operation
- The block scans a virtual padded frame of (IMG_H+2)×(IMG_W+2) positions using counters `vr` (row) and `vc` (column), both reset to 0.
- **Border positions** (vr or vc is 0 or at its maximum): the block injects a zero pixel and consumes no input.
- **Interior positions:** the block consumes one `in_pixel`. `in_ready` = interior && adv_ok.
- **adv_ok** = !out_valid || out_ready.
- **Advance condition:**
  - Border position: adv_ok.
  - Interior position: adv_ok && in_valid.
- **On each advance, with new pixel p:**
  - Each window row shifts left by one tap.
  - Column kc=2 loads: row2 ← p, row1 ← lb1 output, row0 ← lb2 output.
  - Line buffers update: lb1 ← p, lb2 ← lb1 output. Each line buffer has depth IMG_W+2 and uses read-before-write at index `vc`.
- **Emit:** if the advance occurs at vr≥2 and vc≥2, register the updated window and set `out_valid`. The window centre is input pixel (vr-2, vc-2). If `out_valid` was 1 and `out_ready` was 1 with no new emit, clear `out_valid`.
- **Wrap:**
  - vc wraps from IMG_W+1 to 0 and increments vr.
  - vr wraps from IMG_H+1 to 0, and the next frame begins immediately.
  - No line-buffer clear is needed, because the top pad row overwrites stale data.
- **Flags:** `out_first` and `out_last` are registered alongside the window, set from (vr,vc) = (2,2) and (IMG_H+1, IMG_W+1).
- **States:**
  - PAD: border position.
  - PIX: interior position.
  - These are derived from the counters. No separate idle state exists; the block waits in PIX at (1,1) for the first pixel.

## Timing
- **Reset values:** `out_valid`=0, `out_window`=0, `out_first`=0, `out_last`=0, `vr`=`vc`=0. `in_ready` is 0 after reset until the scan reaches (1,1), which takes IMG_W+3 cycles.
- **Latency:** the window centred on (r,c) is valid one cycle after the edge that accepts input (r+1, c+1). Windows on the right and bottom edges follow the corresponding pad advance by one cycle.
- **Throughput:** one advance per cycle when unstalled, so a frame takes (IMG_W+2)(IMG_H+2) cycles minimum.
- **Handshake rules:**
  - `out_window` and the flags remain stable while out_valid && !out_ready.
  - `in_ready` may depend combinationally on `out_ready`; `in_ready` never depends on `in_valid`.
- **Reset mid-frame:** the partial frame is discarded and no window is emitted for it. The next accepted pixel is pixel (0,0) of a new frame.

## Structure
- Package `cnn_pkg` holds:
  - `KERNEL_W`=3 and `KERNEL_H`=3.
  - The tap index function `tap(kr,kc)`.
  - The pixel typedef, parameterised by `DATA_W` and `CH`.
- One sub-module, `line_buffer`: single-port-style delay of IMG_W+2 entries with read-before-write. Two instances, `lb1` and `lb2`. Contents are not reset.

## Test plan
- **Basic frame:** IMG_W=IMG_H=4, CH=1, pixels 1..16 with in_valid and out_ready tied high.
  - Window 1 = [0,0,0,0,1,2,0,5,6] with `out_first`.
  - Window 16 = [11,12,0,15,16,0,0,0,0] with `out_last`.
  - Exactly 16 windows are emitted.
- **Output backpressure:** same frame, with out_ready held low for 10 cycles after window 3.
  - Window 3 is held stable throughout.
  - `in_ready` is 0 throughout.
  - All 16 windows are delivered in order with none lost or duplicated.
- **Input starvation:** in_valid deasserted for 5 cycles before pixel 7.
  - No window is emitted in that period.
  - Window 2 = [0,0,0,1,2,3,5,6,7] follows pixel 7 by one cycle.
- **Back-to-back frames:** 32 pixels streamed continuously.
  - Frame 2, window 1 = [0,0,0,0,17,18,0,21,22].
  - Frame-to-frame window count is 16+16, and frame 2 contains no stale data from frame 1.
- **Reset mid-frame:** rst_n low for 2 cycles after pixel 7.
  - `out_valid` drops immediately.
  - A fresh frame of 1..16 reproduces the basic-frame results exactly.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared kernel geometry, default pixel type and tap indexing for the conv front end.
package cnn_pkg;

    localparam int unsigned KERNEL_W   = 3;
    localparam int unsigned KERNEL_H   = 3;
    localparam int unsigned N_TAPS     = KERNEL_W * KERNEL_H;
    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_CH     = 3;

    typedef logic [DEF_CH*DEF_DATA_W-1:0] pixel_t;

    // Flat tap position inside a window: rows top to bottom, columns left to right.
    function automatic int unsigned tap(input int unsigned kr, input int unsigned kc);
        return kr * KERNEL_W + kc;
    endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out stream bundle between the pixel source, window generator and conv core.
interface conv_window_gen_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CH     = 3
);

    localparam int unsigned PIX_W = CH * DATA_W;
    localparam int unsigned WIN_W = cnn_pkg::N_TAPS * PIX_W;

    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] in_pixel;
    logic             out_valid;
    logic             out_ready;
    logic [WIN_W-1:0] out_window;
    logic             out_first;
    logic             out_last;

    modport master (
        output in_valid, in_pixel, out_ready,
        input  in_ready, out_valid, out_window, out_first, out_last
    );

    modport slave (
        input  in_valid, in_pixel, out_ready,
        output in_ready, out_valid, out_window, out_first, out_last
    );

endinterface

// File: rtl/line_buffer.sv
// One padded raster line of delay; the read at addr sees the value written one line earlier.
module line_buffer #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 258
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata_c
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata_c = mem[addr];

    // Contents are deliberately unreset: the top pad row flushes them each frame.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

endmodule

// File: rtl/conv_window_gen.sv
// Zero-padded 3x3 window generator: scans a virtual (IMG_H+2)x(IMG_W+2) frame and emits
// one raster-ordered window per input pixel using two line buffers.
module conv_window_gen
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CH     = 3,
    parameter int unsigned IMG_W  = 256,
    parameter int unsigned IMG_H  = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    conv_window_gen_if.slave bus
);

    localparam int unsigned PIX_W = CH * DATA_W;
    localparam int unsigned WIN_W = N_TAPS * PIX_W;
    localparam int unsigned VC_W  = $clog2(IMG_W + 2);
    localparam int unsigned VR_W  = $clog2(IMG_H + 2);
    localparam logic [VC_W-1:0] VC_MAX = VC_W'(IMG_W + 1);
    localparam logic [VR_W-1:0] VR_MAX = VR_W'(IMG_H + 1);

    typedef enum logic {PAD, PIX} state_t;

    state_t           state_q, state_d;
    logic [VR_W-1:0]  vr_q, vr_d;
    logic [VC_W-1:0]  vc_q, vc_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [WIN_W-1:0] out_window_d;
    logic             out_valid_d, out_first_d, out_last_d;
    logic             adv_ok, advance;
    logic [PIX_W-1:0] pix, lb1_rd, lb2_rd;

    assign adv_ok       = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = (state_q == PIX) && adv_ok;
    assign advance      = adv_ok && ((state_q == PAD) || bus.in_valid);
    assign pix          = (state_q == PIX) ? bus.in_pixel : '0;

    line_buffer #(.WIDTH(PIX_W), .DEPTH(IMG_W + 2)) lb1 (
        .clk     (clk),
        .we      (advance),
        .addr    (vc_q),
        .wdata   (pix),
        .rdata_c (lb1_rd)
    );

    line_buffer #(.WIDTH(PIX_W), .DEPTH(IMG_W + 2)) lb2 (
        .clk     (clk),
        .we      (advance),
        .addr    (vc_q),
        .wdata   (lb1_rd),
        .rdata_c (lb2_rd)
    );

    // Scan position, window shift and output register update.
    always_comb begin
        state_d      = state_q;
        vr_d         = vr_q;
        vc_d         = vc_q;
        win_d        = win_q;
        out_valid_d  = bus.out_valid;
        out_window_d = bus.out_window;
        out_first_d  = bus.out_first;
        out_last_d   = bus.out_last;

        if (bus.out_valid && bus.out_ready) out_valid_d = 1'b0;

        if (advance) begin
            for (int unsigned kr = 0; kr < KERNEL_H; kr++) begin
                for (int unsigned kc = 0; kc < KERNEL_W - 1; kc++) begin
                    win_d[tap(kr, kc)*PIX_W +: PIX_W] = win_q[tap(kr, kc + 1)*PIX_W +: PIX_W];
                end
            end
            win_d[tap(2, KERNEL_W - 1)*PIX_W +: PIX_W] = pix;
            win_d[tap(1, KERNEL_W - 1)*PIX_W +: PIX_W] = lb1_rd;
            win_d[tap(0, KERNEL_W - 1)*PIX_W +: PIX_W] = lb2_rd;

            if (vc_q == VC_MAX) begin
                vc_d = '0;
                vr_d = (vr_q == VR_MAX) ? '0 : vr_q + VR_W'(1);
            end else begin
                vc_d = vc_q + VC_W'(1);
            end

            // Window centre is input pixel (vr-2, vc-2) once two rows and columns are in.
            if (vr_q >= VR_W'(2) && vc_q >= VC_W'(2)) begin
                out_valid_d  = 1'b1;
                out_window_d = win_d;
                out_first_d  = (vr_q == VR_W'(2)) && (vc_q == VC_W'(2));
                out_last_d   = (vr_q == VR_MAX) && (vc_q == VC_MAX);
            end

            state_d = (vr_d == '0 || vr_d == VR_MAX || vc_d == '0 || vc_d == VC_MAX) ? PAD : PIX;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= PAD;
            vr_q           <= '0;
            vc_q           <= '0;
            win_q          <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_window <= '0;
            bus.out_first  <= 1'b0;
            bus.out_last   <= 1'b0;
        end else begin
            state_q        <= state_d;
            vr_q           <= vr_d;
            vc_q           <= vc_d;
            win_q          <= win_d;
            bus.out_valid  <= out_valid_d;
            bus.out_window <= out_window_d;
            bus.out_first  <= out_first_d;
            bus.out_last   <= out_last_d;
        end
    end

endmodule
